// File: rtl/fifo_wptr_gray_if.sv
// Write-side pointer bus for the asynchronous FIFO: push handshake in,
// RAM write controls, published Gray pointer and occupancy status out.
interface fifo_wptr_gray_if #(
  parameter int ADDR_W = 4
);
  logic              wr_en_i;
  logic [ADDR_W:0]   rptr_gray_i;
  logic              wr_o;
  logic [ADDR_W-1:0] waddr_o;
  logic [ADDR_W:0]   wptr_gray_o;
  logic              full_o;
  logic [ADDR_W:0]   level_o;

  // Writer / read-pointer synchronizer side.
  modport master (
    output wr_en_i, rptr_gray_i,
    input  wr_o, waddr_o, wptr_gray_o, full_o, level_o
  );

  // Pointer manager side.
  modport slave (
    input  wr_en_i, rptr_gray_i,
    output wr_o, waddr_o, wptr_gray_o, full_o, level_o
  );
endinterface

// File: rtl/fifo_wptr_gray.sv
// Write-domain pointer manager for the asynchronous FIFO. Keeps the binary
// write pointer, publishes a flop-driven Gray copy for the read-domain
// synchronizer, and produces registered full flag and fill level against
// the already-synchronized Gray read pointer.
module fifo_wptr_gray #(
  parameter int ADDR_W = 4
) (
  input logic             clk,
  input logic             nreset,
  fifo_wptr_gray_if.slave bus
);

  localparam int PW = ADDR_W + 1;

  // Full when the write pointer is exactly one lap ahead: in Gray code that
  // means the top two bits inverted and the rest equal. Built as an XOR mask
  // so the ADDR_W=1 case (compare against ~rptr[1:0]) needs no special slice.
  localparam logic [PW-1:0] FULL_MASK = {PW{1'b1}} ^ ({PW{1'b1}} >> 2);

  logic [PW-1:0] wbin_q, wbin_d;
  logic [PW-1:0] gray_q, gray_d;
  logic [PW-1:0] level_q, level_d;
  logic          full_q, full_d;
  logic [PW-1:0] rbin;
  logic          wr;

  // A push is accepted only against the current registered full flag.
  assign wr = bus.wr_en_i & ~full_q;

  // Decode the read pointer to binary by XOR-reduction from the MSB down.
  always_comb begin
    // NOTE: every bit is assigned on every pass, so no latch is inferred.
    rbin = '0;
    rbin[ADDR_W] = bus.rptr_gray_i[ADDR_W];
    for (int i = ADDR_W - 1; i >= 0; i--) begin
      rbin[i] = rbin[i+1] ^ bus.rptr_gray_i[i];
    end
  end

  // Next pointer, its Gray image, and status computed from the next pointer
  // so flags line up with the pointer the read side will see.
  always_comb begin
    wbin_d  = wbin_q + PW'(wr);
    gray_d  = wbin_d ^ (wbin_d >> 1);
    full_d  = (gray_d == (bus.rptr_gray_i ^ FULL_MASK));
    level_d = wbin_d - rbin;
  end

  // Pointer and status registers; Gray output comes straight from a flop so
  // the crossing sees single-bit transitions only.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      wbin_q  <= '0;
      gray_q  <= '0;
      full_q  <= 1'b0;
      level_q <= '0;
    end else begin
      // NOTE: non-blocking so all registers update from pre-edge values.
      wbin_q  <= wbin_d;
      gray_q  <= gray_d;
      full_q  <= full_d;
      level_q <= level_d;
    end
  end

  assign bus.wr_o        = wr;
  assign bus.waddr_o     = wbin_q[ADDR_W-1:0];
  assign bus.wptr_gray_o = gray_q;
  assign bus.full_o      = full_q;
  assign bus.level_o     = level_q;

endmodule

// File: tb/tb_fifo_wptr_gray.sv
// Directed bench for fifo_wptr_gray at ADDR_W=2 (depth 4): reset, fill,
// overflow, drain, pointer wrap and asynchronous mid-fill reset, plus
// continuous checks on Gray single-bit steps, accept gating and level range.
module tb_fifo_wptr_gray;

  localparam int ADDR_W = 2;

  logic clk;
  logic nreset;
  int   n_cmp;
  int   n_err;

  fifo_wptr_gray_if #(.ADDR_W(ADDR_W)) bus ();

  fifo_wptr_gray #(.ADDR_W(ADDR_W)) dut (
    .clk    (clk),
    .nreset (nreset),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Continuous properties, sampled on the falling edge.
  logic [2:0] prev_gray;
  logic       prev_ok;
  always @(negedge clk) begin
    if (!nreset) begin
      prev_ok = 1'b0;
    end else begin
      if (prev_ok) begin
        n_cmp++;
        if ($countones(bus.wptr_gray_o ^ prev_gray) > 1) begin
          n_err++;
          $display("FAIL gray_hamming got %b prev %b want <=1 bit change", bus.wptr_gray_o, prev_gray);
        end
      end
      n_cmp++;
      if (bus.wr_o && bus.full_o) begin
        n_err++;
        $display("FAIL wr_while_full got wr_o=1 full_o=1 want wr_o=0");
      end
      n_cmp++;
      if (bus.level_o > 3'd4) begin
        n_err++;
        $display("FAIL level_range got %0d want <=4", bus.level_o);
      end
      prev_gray = bus.wptr_gray_o;
      prev_ok   = 1'b1;
    end
  end

  task automatic test_reset();
    nreset = 1'b0;
    bus.wr_en_i = 1'b0;
    bus.rptr_gray_i = 3'b000;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({bus.wptr_gray_o, bus.waddr_o, bus.full_o, bus.level_o} !== 9'd0) begin
      n_err++;
      $display("FAIL reset_hold got g=%b a=%0d f=%b l=%0d want all 0",
               bus.wptr_gray_o, bus.waddr_o, bus.full_o, bus.level_o);
    end
    nreset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if ({bus.wptr_gray_o, bus.waddr_o, bus.full_o, bus.level_o} !== 9'd0) begin
        n_err++;
        $display("FAIL reset_idle[%0d] got g=%b a=%0d f=%b l=%0d want all 0",
                 i, bus.wptr_gray_o, bus.waddr_o, bus.full_o, bus.level_o);
      end
    end
  endtask

  task automatic test_fill();
    logic [2:0] exp_g [4] = '{3'b001, 3'b011, 3'b010, 3'b110};
    logic [1:0] exp_a [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
    logic [2:0] exp_l [4] = '{3'd1, 3'd2, 3'd3, 3'd4};
    logic       exp_f [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.wr_en_i = 1'b1;
      #1;
      n_cmp++;
      if (bus.wr_o !== 1'b1) begin
        n_err++;
        $display("FAIL fill_wr[%0d] got %b want 1", i, bus.wr_o);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (bus.wptr_gray_o !== exp_g[i] || bus.waddr_o !== exp_a[i] ||
          bus.level_o !== exp_l[i] || bus.full_o !== exp_f[i]) begin
        n_err++;
        $display("FAIL fill[%0d] got g=%b a=%0d l=%0d f=%b want g=%b a=%0d l=%0d f=%b",
                 i, bus.wptr_gray_o, bus.waddr_o, bus.level_o, bus.full_o,
                 exp_g[i], exp_a[i], exp_l[i], exp_f[i]);
      end
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.wr_en_i = 1'b1;
      #1;
      n_cmp++;
      if (bus.wr_o !== 1'b0) begin
        n_err++;
        $display("FAIL ovf_wr[%0d] got %b want 0", i, bus.wr_o);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (bus.wptr_gray_o !== 3'b110 || bus.level_o !== 3'd4 || bus.full_o !== 1'b1) begin
        n_err++;
        $display("FAIL ovf[%0d] got g=%b l=%0d f=%b want g=110 l=4 f=1",
                 i, bus.wptr_gray_o, bus.level_o, bus.full_o);
      end
    end
  endtask

  task automatic test_drain();
    @(negedge clk);
    bus.wr_en_i = 1'b0;
    bus.rptr_gray_i = 3'b001;
    @(posedge clk); #1;
    n_cmp++;
    if (bus.full_o !== 1'b0 || bus.level_o !== 3'd3 || bus.wptr_gray_o !== 3'b110) begin
      n_err++;
      $display("FAIL drain got g=%b l=%0d f=%b want g=110 l=3 f=0",
               bus.wptr_gray_o, bus.level_o, bus.full_o);
    end
    @(negedge clk);
    bus.wr_en_i = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (bus.full_o !== 1'b1 || bus.level_o !== 3'd4 || bus.wptr_gray_o !== 3'b111) begin
      n_err++;
      $display("FAIL refill got g=%b l=%0d f=%b want g=111 l=4 f=1",
               bus.wptr_gray_o, bus.level_o, bus.full_o);
    end
  endtask

  task automatic test_wrap();
    // Read side catches up to write pointer minus one: rbin 2,3,4.
    logic [2:0] pre_r [3] = '{3'b011, 3'b010, 3'b110};
    logic [2:0] pre_l [3] = '{3'd3, 3'd2, 3'd1};
    // Each push accompanied by read pointer = old write pointer (wbin 5..14).
    logic [2:0] loop_r [10] = '{3'b111, 3'b101, 3'b100, 3'b000, 3'b001,
                                3'b011, 3'b010, 3'b110, 3'b111, 3'b101};
    logic [2:0] loop_g [10] = '{3'b101, 3'b100, 3'b000, 3'b001, 3'b011,
                                3'b010, 3'b110, 3'b111, 3'b101, 3'b100};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.wr_en_i = 1'b0;
      bus.rptr_gray_i = pre_r[i];
      @(posedge clk); #1;
      n_cmp++;
      if (bus.level_o !== pre_l[i] || bus.full_o !== 1'b0) begin
        n_err++;
        $display("FAIL predrain[%0d] got l=%0d f=%b want l=%0d f=0",
                 i, bus.level_o, bus.full_o, pre_l[i]);
      end
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.wr_en_i = 1'b1;
      bus.rptr_gray_i = loop_r[i];
      @(posedge clk); #1;
      n_cmp++;
      if (bus.wptr_gray_o !== loop_g[i] || bus.level_o !== 3'd1 || bus.full_o !== 1'b0) begin
        n_err++;
        $display("FAIL wrap[%0d] got g=%b l=%0d f=%b want g=%b l=1 f=0",
                 i, bus.wptr_gray_o, bus.level_o, bus.full_o, loop_g[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    // wbin 7 -> 0 with read advancing (level 1), then 0 -> 1 held (level 2).
    @(negedge clk);
    bus.wr_en_i = 1'b1;
    bus.rptr_gray_i = 3'b100;
    @(negedge clk);
    @(posedge clk); #1;
    n_cmp++;
    if (bus.wptr_gray_o !== 3'b001 || bus.level_o !== 3'd2) begin
      n_err++;
      $display("FAIL premid got g=%b l=%0d want g=001 l=2", bus.wptr_gray_o, bus.level_o);
    end
    #2;
    nreset = 1'b0;
    #1;
    n_cmp++;
    if ({bus.wptr_gray_o, bus.waddr_o, bus.full_o, bus.level_o} !== 9'd0) begin
      n_err++;
      $display("FAIL async_rst got g=%b a=%0d f=%b l=%0d want all 0",
               bus.wptr_gray_o, bus.waddr_o, bus.full_o, bus.level_o);
    end
    @(negedge clk);
    bus.wr_en_i = 1'b0;
    bus.rptr_gray_i = 3'b000;
    nreset = 1'b1;
    @(negedge clk);
    bus.wr_en_i = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (bus.wptr_gray_o !== 3'b001 || bus.waddr_o !== 2'd1 || bus.level_o !== 3'd1) begin
      n_err++;
      $display("FAIL post_rst got g=%b a=%0d l=%0d want g=001 a=1 l=1",
               bus.wptr_gray_o, bus.waddr_o, bus.level_o);
    end
    @(negedge clk);
    bus.wr_en_i = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_fill();
    test_overflow();
    test_drain();
    test_wrap();
    test_async_reset();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
